// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the hazard scoreboard: entry record, bubble value
// and parameter defaults.
package hazard_scoreboard_pkg;

    localparam int REG_AW_DEF       = 3;
    localparam int DEPTH_DEF        = 3;
    localparam int FWD_EN_DEF       = 0;
    localparam int FLUSH_STAGES_DEF = 2;
    localparam int ZERO_REG_DEF     = 0;
    localparam int CNT_W_DEF        = 16;

    // Entries carry a fixed-width rd so the record type needs no parameter.
    // REG_AW must not exceed MAX_AW.
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              isLoad;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    function automatic logic srcMatch(input logic used, input logic [MAX_AW-1:0] src,
                                      input entry_t e, input logic zeroReg);
        return used && e.valid && (e.rd == src) && !(zeroReg && (src == '0));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage request and stall response bundle between the IFID stage
// (master) and the scoreboard (slave).
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_regwrite, id_is_load, flush,
        input  stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_regwrite, id_is_load, flush,
        output stall, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_stage.sv
// One scoreboard pipeline register: enable-gated flop with synchronous
// squash to a bubble.
module sb_entry_stage
    import hazard_scoreboard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   squash,
    input  entry_t d,
    output entry_t q
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= BUBBLE;
        end else if (squash) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight destinations and stalls the
// decode stage on read-after-write conflicts.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int FWD_EN       = FWD_EN_DEF,
    parameter int FLUSH_STAGES = FLUSH_STAGES_DEF,
    parameter int ZERO_REG     = ZERO_REG_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    entry_t            stageD [DEPTH];
    entry_t            stageQ [DEPTH];
    entry_t            headEntry;
    logic [MAX_AW-1:0] rs1Ext;
    logic [MAX_AW-1:0] rs2Ext;
    logic              hazard;
    logic              stallInt;
    logic              issue;
    logic [CNT_W-1:0]  stallCnt;

    assign rs1Ext = MAX_AW'(sb.id_rs1);
    assign rs2Ext = MAX_AW'(sb.id_rs2);

    // Uses only the current (pre-edge) entries, so a retiring entry still counts.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((FWD_EN == 0) || ((k == 0) && stageQ[0].isLoad)) begin
                if (srcMatch(sb.id_rs1_used, rs1Ext, stageQ[k], ZERO_REG != 0) ||
                    srcMatch(sb.id_rs2_used, rs2Ext, stageQ[k], ZERO_REG != 0)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign stallInt = sb.id_valid && hazard && !sb.flush;
    assign issue    = sb.id_valid && sb.id_regwrite && !stallInt && !sb.flush;

    always_comb begin
        headEntry = BUBBLE;
        if (issue) begin
            headEntry.valid  = 1'b1;
            headEntry.rd     = MAX_AW'(sb.id_rd);
            headEntry.isLoad = sb.id_is_load;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        localparam logic SQUASHABLE = (g < FLUSH_STAGES);

        if (g == 0) begin : gHead
            assign stageD[g] = headEntry;
        end else begin : gBody
            assign stageD[g] = stageQ[g-1];
        end

        sb_entry_stage uStage (
            .clk    (clk),
            .rst    (rst),
            .en     (1'b1),
            .squash (sb.flush && SQUASHABLE),
            .d      (stageD[g]),
            .q      (stageQ[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (stallInt && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign sb.stall     = stallInt;
    assign sb.stall_cnt = stallCnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four configurations driven from one
// vector table plus a hand-written reset-during-stall sequence.
module tb_hazard_scoreboard;

    typedef struct {
        logic [1:0]  dut;
        logic        v;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        u1;
        logic        u2;
        logic [2:0]  rd;
        logic        rw;
        logic        ld;
        logic        fl;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       idValid = 1'b0, rs1Used = 1'b0, rs2Used = 1'b0;
    logic       regWrite = 1'b0, isLoad = 1'b0, flushIn = 1'b0;
    logic [2:0] rs1 = 3'd0, rs2 = 3'd0, rd = 3'd0;

    int nChecks = 0;
    int nPass   = 0;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) ifA ();
    hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) ifF ();
    hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) ifZ ();
    hazard_scoreboard_if #(.REG_AW(3), .CNT_W(2))  ifC ();

    hazard_scoreboard #(.FWD_EN(0)) dutA (.clk(clk), .rst(rst), .sb(ifA));
    hazard_scoreboard #(.FWD_EN(1)) dutF (.clk(clk), .rst(rst), .sb(ifF));
    hazard_scoreboard #(.ZERO_REG(1)) dutZ (.clk(clk), .rst(rst), .sb(ifZ));
    hazard_scoreboard #(.CNT_W(2)) dutC (.clk(clk), .rst(rst), .sb(ifC));

    assign ifA.id_valid = idValid && (sel == 2'd0);
    assign ifF.id_valid = idValid && (sel == 2'd1);
    assign ifZ.id_valid = idValid && (sel == 2'd2);
    assign ifC.id_valid = idValid && (sel == 2'd3);
    assign ifA.flush = flushIn && (sel == 2'd0);
    assign ifF.flush = flushIn && (sel == 2'd1);
    assign ifZ.flush = flushIn && (sel == 2'd2);
    assign ifC.flush = flushIn && (sel == 2'd3);

    assign ifA.id_rs1 = rs1;  assign ifF.id_rs1 = rs1;  assign ifZ.id_rs1 = rs1;  assign ifC.id_rs1 = rs1;
    assign ifA.id_rs2 = rs2;  assign ifF.id_rs2 = rs2;  assign ifZ.id_rs2 = rs2;  assign ifC.id_rs2 = rs2;
    assign ifA.id_rd  = rd;   assign ifF.id_rd  = rd;   assign ifZ.id_rd  = rd;   assign ifC.id_rd  = rd;
    assign ifA.id_rs1_used = rs1Used;  assign ifF.id_rs1_used = rs1Used;
    assign ifZ.id_rs1_used = rs1Used;  assign ifC.id_rs1_used = rs1Used;
    assign ifA.id_rs2_used = rs2Used;  assign ifF.id_rs2_used = rs2Used;
    assign ifZ.id_rs2_used = rs2Used;  assign ifC.id_rs2_used = rs2Used;
    assign ifA.id_regwrite = regWrite; assign ifF.id_regwrite = regWrite;
    assign ifZ.id_regwrite = regWrite; assign ifC.id_regwrite = regWrite;
    assign ifA.id_is_load  = isLoad;   assign ifF.id_is_load  = isLoad;
    assign ifZ.id_is_load  = isLoad;   assign ifC.id_is_load  = isLoad;

    logic [3:0]  stallV;
    logic [15:0] cntV [4];
    assign stallV  = {ifC.stall, ifZ.stall, ifF.stall, ifA.stall};
    assign cntV[0] = ifA.stall_cnt;
    assign cntV[1] = ifF.stall_cnt;
    assign cntV[2] = ifZ.stall_cnt;
    assign cntV[3] = 16'(ifC.stall_cnt);

    function automatic vec_t mk(input int dut, input int v, input int r1, input int r2,
                                input int u1, input int u2, input int d, input int rw,
                                input int ld, input int fl, input int st, input int cnt);
        vec_t t;
        t.dut = 2'(dut); t.v = 1'(v); t.rs1 = 3'(r1); t.rs2 = 3'(r2);
        t.u1 = 1'(u1); t.u2 = 1'(u2); t.rd = 3'(d); t.rw = 1'(rw);
        t.ld = 1'(ld); t.fl = 1'(fl); t.st = 1'(st); t.cnt = 16'(cnt);
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          dut v rs1 rs2 u1 u2 rd rw ld fl  st cnt
        // config A: FWD_EN=0, DEPTH=3, FLUSH_STAGES=2, ZERO_REG=0
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[3]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 2);
        vecs[4]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 3);
        vecs[6]  = mk(0, 1, 0, 4, 0, 1, 0, 0, 0, 1, 0, 3);
        vecs[7]  = mk(0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 3);
        vecs[8]  = mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 3);
        vecs[9]  = mk(0, 1, 5, 6, 1, 1, 3, 1, 0, 0, 0, 3);
        vecs[10] = mk(0, 1, 3, 3, 1, 1, 7, 1, 0, 0, 1, 3);
        vecs[11] = mk(0, 1, 3, 3, 1, 1, 7, 1, 0, 0, 1, 4);
        vecs[12] = mk(0, 1, 3, 3, 1, 1, 7, 1, 0, 0, 1, 5);
        vecs[13] = mk(0, 1, 3, 3, 1, 1, 7, 1, 0, 0, 0, 6);
        vecs[14] = mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 6);
        vecs[15] = mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        vecs[16] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6);
        vecs[17] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 6);
        vecs[18] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 7);
        vecs[19] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8);
        vecs[20] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9);
        // config F: FWD_EN=1, only load-use in entry[0] stalls
        vecs[21] = mk(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        vecs[22] = mk(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 1, 0);
        vecs[23] = mk(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[24] = mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
        vecs[25] = mk(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[26] = mk(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1);
        // config Z: ZERO_REG=1
        vecs[27] = mk(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[28] = mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[29] = mk(2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // config C: CNT_W=2, six stall cycles saturate at 3
        vecs[30] = mk(3, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        vecs[31] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 0);
        vecs[32] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 1);
        vecs[33] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 2);
        vecs[34] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 0, 3);
        vecs[35] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 3);
        vecs[36] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 3);
        vecs[37] = mk(3, 1, 6, 0, 1, 0, 6, 1, 0, 0, 1, 3);
        vecs[38] = mk(3, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        vecs[39] = mk(3, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 3);

        rst = 1'b0;
        step();
        step();
        for (int d = 0; d < 4; d++) begin
            chk("reset_stall", d, 16'(stallV[d]), 16'd0);
            chk("reset_cnt", d, cntV[d], 16'd0);
        end
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].dut;
            idValid = vecs[i].v;   rs1 = vecs[i].rs1;    rs2 = vecs[i].rs2;
            rs1Used = vecs[i].u1;  rs2Used = vecs[i].u2; rd = vecs[i].rd;
            regWrite = vecs[i].rw; isLoad = vecs[i].ld;  flushIn = vecs[i].fl;
            #3;
            chk("vec_stall", i, 16'(stallV[vecs[i].dut]), 16'(vecs[i].st));
            chk("vec_cnt", i, cntV[vecs[i].dut], vecs[i].cnt);
            step();
        end

        // Reset in the middle of a stall on config A.
        sel = 2'd0; flushIn = 1'b0; isLoad = 1'b0; rs2 = 3'd0; rs2Used = 1'b0;
        idValid = 1'b1; rs1 = 3'd0; rs1Used = 1'b0; rd = 3'd2; regWrite = 1'b1;
        #3;
        chk("rst_seq_writer", 0, 16'(ifA.stall), 16'd0);
        step();
        rs1 = 3'd2; rs1Used = 1'b1; rd = 3'd0; regWrite = 1'b0;
        #3;
        chk("rst_seq_stall", 1, 16'(ifA.stall), 16'd1);
        chk("rst_seq_cnt", 1, cntV[0], 16'd9);
        step();
        #3;
        chk("rst_seq_stall", 2, 16'(ifA.stall), 16'd1);
        chk("rst_seq_cnt", 2, cntV[0], 16'd10);
        rst = 1'b0;
        step();
        chk("rst_seq_stall_in_reset", 3, 16'(ifA.stall), 16'd0);
        chk("rst_seq_cnt_in_reset", 3, cntV[0], 16'd0);
        chk("rst_seq_cntC_in_reset", 3, cntV[3], 16'd0);
        rst = 1'b1;
        #3;
        chk("rst_seq_stall_after", 4, 16'(ifA.stall), 16'd0);
        step();
        chk("rst_seq_cnt_after", 5, cntV[0], 16'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 3: register-address width.
REQ-002 Parameter DEPTH, default 3: tracked in-flight stages (IDEX, EXMEM, MEMWB, ...), range 1..8.
REQ-003 Parameter FWD_EN, default 0: 1 means the datapath forwards, so only load-use hazards stall.
REQ-004 Parameter FLUSH_STAGES, default 2: number of youngest scoreboard entries squashed on flush, range 1..DEPTH.
REQ-005 Parameter ZERO_REG, default 0: 1 means register 0 never creates a hazard.
REQ-006 Parameter CNT_W, default 16: stall-counter width.
REQ-007 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  instruction present in IFID.
- id_rs1, id_rs2  in  REG_AW  source addresses.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_AW  destination.
- id_regwrite  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch or jump; squash younger work.
- stall  out  1  hold PC/IFID and insert a bubble into IDEX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-008 Hold a shift pipeline entry[0..DEPTH-1], each {valid, rd, is_load}; entry[0] is IDEX and higher indices are older.
REQ-009 Every cycle: entry[k+1] <= entry[k] for k < DEPTH-1; the oldest entry retires.
REQ-010 entry[0] <= {1, id_rd, id_is_load} iff id_valid & id_regwrite & !stall & !flush; otherwise entry[0] <= bubble (valid=0).
REQ-011 A source matches when: it is used, it equals a valid entry's rd, and not (ZERO_REG=1 and address=0).
REQ-012 With FWD_EN=0, hazard = a source matches any entry[0..DEPTH-1].
REQ-013 With FWD_EN=1, hazard = a source matches entry[0] and entry[0].is_load=1.
REQ-014 stall = id_valid & hazard & !flush; it is combinational, with zero-cycle latency from inputs.
REQ-015 flush has priority over stall. On flush, next-state entries with index < FLUSH_STAGES are invalid, overriding REQ-009/010; older entries shift normally.
REQ-016 A stall persists naturally until the matching entry retires (FWD_EN=0) or leaves entry[0] (FWD_EN=1); no extra stall cycles are added.
REQ-017 stall_cnt increments by 1 in each cycle stall=1 and saturates at all-ones without wrapping.
REQ-018 With id_rs1=id_rs2 both matching, behaviour is a single hazard and the count increments by 1, not 2.
REQ-019 If the oldest entry retires in the same cycle a later one matches, hazard evaluation uses current (pre-edge) entries only.

Reset
REQ-020 When rst=0 at a clock edge, every entry becomes invalid and stall_cnt becomes 0.
REQ-021 During reset, stall reads 0 after the first reset edge, because no entry is valid.
REQ-022 Reset asserted mid-stall terminates the stall on the next cycle; there is no residual state.

Structure
REQ-023 Entry record type, bubble constant and parameter defaults belong in the shared pipeline package.
REQ-024 One sub-module, sb_entry_stage (single register stage with valid/squash), is instantiated DEPTH times.
REQ-025 Storage uses dff_en-style flops; no latches and no asynchronous paths.

Verification
REQ-026 FWD_EN=0, DEPTH=3: issue rd=2 with regwrite, then next instruction reads rs1=2 -> stall=1 for exactly 3 cycles, then stall_cnt=3.
REQ-027 FWD_EN=1: load rd=5, then next instruction reads rs2=5 -> stall=1 for 1 cycle; repeating with a non-load gives stall=0 throughout.
REQ-028 rd=4 issued, hazard pending, flush=1 asserted -> stall=0 that cycle; with FLUSH_STAGES=2, entry[0] and entry[1] are invalid next cycle and a reader of r4 does not stall.
REQ-029 ZERO_REG=1: writer rd=0 followed by reader rs1=0 -> stall=0; with ZERO_REG=0 -> stall asserts.
REQ-030 CNT_W=2: force 5 stall cycles -> stall_cnt reads 3 and holds.
REQ-031 Reset (rst=0) for one cycle during a 3-cycle stall -> stall=0 and stall_cnt=0 the cycle after reset.
